// File: rtl/sobel_window_gen_pkg.sv
// Shared configuration for the Sobel window generator: image geometry,
// kernel size and the pixel/window types passed to conv_block_sobel.
package sobel_window_gen_pkg;

    localparam int NBIT        = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int IMG_WIDTH   = 8;
    localparam int IMG_HEIGHT  = 6;

    typedef logic [NBIT-1:0] pixel_t;
    typedef pixel_t [KERNEL_SIZE-1:0] column_t;
    typedef pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] window_t;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel stream in, KxK window stream out; the master side is the pixel
// source that also consumes the windows, the slave side is the generator.
interface sobel_window_gen_if;
    import sobel_window_gen_pkg::*;

    pixel_t  i_pixel;
    logic    i_pixel_valid;
    window_t o_data;
    logic    o_data_valid;
    logic    o_frame_done;

    modport master (
        output i_pixel, i_pixel_valid,
        input  o_data, o_data_valid, o_frame_done
    );

    modport slave (
        input  i_pixel, i_pixel_valid,
        output o_data, o_data_valid, o_frame_done
    );

endinterface

// File: rtl/sobel_window_gen_line_buffer.sv
// One image line of storage, circularly addressed by column, with a
// registered read that always returns the previous line's pixel at i_addr.
module line_buffer #(
    parameter int NBIT  = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_addr,
    input  logic [NBIT-1:0] i_din,
    output logic [NBIT-1:0] o_dout
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    logic [NBIT-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_addr;

    // The read is prefetched for the column the next accepted pixel will
    // use, so o_dout already holds the old entry when that write happens.
    always_comb begin
        rd_addr = i_addr;
        if (i_wr_en) begin
            rd_addr = (i_addr == ADDR_LAST) ? '0 : i_addr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_addr] <= i_din;
        end
        o_dout <= mem[rd_addr];
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-order pixel stream to KxK neighbourhood generator ("valid" windows
// only) feeding conv_block_sobel.
module sobel_window_gen
    import sobel_window_gen_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rstn,
    sobel_window_gen_if.slave  bus
);

    localparam int K  = KERNEL_SIZE;
    localparam int AW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    localparam logic [AW-1:0] X_LAST  = AW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [AW-1:0] X_FIRST = AW'(K - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);

    logic [AW-1:0] x;
    logic [YW-1:0] y;
    pixel_t        lb_dout [K-1];
    column_t       new_col;
    window_t       window;
    window_t       window_next;
    logic          emit;
    logic          last_pixel;

    // Buffer k holds line y-1-k; each one feeds the next in the cascade.
    for (genvar k = 0; k < K - 1; k++) begin : g_lb
        if (k == 0) begin : g_head
            line_buffer #(.NBIT(NBIT), .DEPTH(IMG_WIDTH)) u_lb (
                .i_clk   (i_clk),
                .i_wr_en (bus.i_pixel_valid),
                .i_addr  (x),
                .i_din   (bus.i_pixel),
                .o_dout  (lb_dout[k])
            );
        end else begin : g_tail
            line_buffer #(.NBIT(NBIT), .DEPTH(IMG_WIDTH)) u_lb (
                .i_clk   (i_clk),
                .i_wr_en (bus.i_pixel_valid),
                .i_addr  (x),
                .i_din   (lb_dout[k-1]),
                .o_dout  (lb_dout[k])
            );
        end
    end

    always_comb begin
        new_col     = '0;
        window_next = window;
        new_col[K-1] = bus.i_pixel;
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = lb_dout[K-2-r];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                window_next[r][c] = window[r][c+1];
            end
            window_next[r][K-1] = new_col[r];
        end
    end

    // The x/y gates drop windows that would mix two lines or two frames.
    assign emit       = bus.i_pixel_valid && (x >= X_FIRST) && (y >= Y_FIRST);
    assign last_pixel = bus.i_pixel_valid && (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x                <= '0;
            y                <= '0;
            window           <= '0;
            bus.o_data       <= '0;
            bus.o_data_valid <= 1'b0;
            bus.o_frame_done <= 1'b0;
        end else begin
            bus.o_data_valid <= emit;
            bus.o_frame_done <= last_pixel;
            if (bus.i_pixel_valid) begin
                window <= window_next;
                if (emit) begin
                    bus.o_data <= window_next;
                end
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming window generator feeding `conv_block_sobel` in the Canny pipeline. It accepts a raster-order pixel stream, one pixel per accepted cycle, and buffers KERNEL_SIZE-1 image lines. It emits the full KERNEL_SIZE×KERNEL_SIZE neighbourhood plus a one-cycle valid, in the exact array shape `conv_block_sobel` consumes on `i_data`/`i_data_valid`. It generates windows only where they lie fully inside the image ("valid" convolution, no padding).

## Interface
- NBIT, `NBIT: pixel width (unsigned)
- KERNEL_SIZE, `KERNEL_SIZE: window side (3 for Sobel); must be ≥ 2
- IMG_WIDTH, `IMG_WIDTH: pixels per line; must be ≥ KERNEL_SIZE
- IMG_HEIGHT, `IMG_HEIGHT: lines per frame; must be ≥ KERNEL_SIZE

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_pixel  in  NBIT  input pixel
- i_pixel_valid  in  1  pixel accept strobe; no backpressure
- o_data  out  [NBIT-1:0] [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0]  window
- o_data_valid  out  1  window valid, one cycle per window
- o_frame_done  out  1  one-cycle pulse after last pixel of a frame

## Operation
- Pixel p(y,x) is the pixel accepted at column counter x and row counter y.
- Counters: x in 0..IMG_WIDTH-1; y in 0..IMG_HEIGHT-1. Both advance only on i_pixel_valid.
- x wraps to 0 and y increments at end of line. At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0; the next pixel starts a new frame.
- Line buffers: KERNEL_SIZE-1 cascaded buffers, each IMG_WIDTH deep.
  - Each is a circular store addressed by x and uses read-before-write.
  - Buffer k outputs p(y-1-k, x).
- Window shift register: on each accept every row shifts left by one column.
  - New column c=KERNEL_SIZE-1, top to bottom: p(y-K+1,x) … p(y-1,x), p(y,x).
- Indexing: o_data[r][c] = p(y-K+1+r, x-K+1+c). r=0 is the oldest row, c=0 the leftmost column.
- Window emit: pulse o_data_valid when the accepted pixel has y ≥ K-1 and x ≥ K-1.
  - Windows per frame: (IMG_WIDTH-K+1)·(IMG_HEIGHT-K+1).
- Windows never straddle a line wrap: the x ≥ K-1 gate discards columns mixed from the previous line.
- Windows never straddle a frame: the y ≥ K-1 gate discards rows from the previous frame, so line-buffer contents need no clearing.
- Pixels pass through unmodified; no arithmetic, no width change.

## Timing
- Reset values (asynchronous, while i_rstn=0): o_data all 0, o_data_valid 0, o_frame_done 0, x=y=0. Shift register cleared; line-buffer RAM not cleared.
- Latency: o_data_valid and o_data update on the rising edge that accepts the completing pixel. They are visible the following cycle.
- o_data holds its last value while o_data_valid=0.
- Gaps: i_pixel_valid=0 freezes counters, buffers and window, and drives o_data_valid=0. Throughput is 1 window/cycle under continuous input.
- o_frame_done: asserted in the same cycle as the o_data_valid for window (IMG_HEIGHT-1, IMG_WIDTH-1).
- Reset mid-frame: all outputs drop immediately. The first pixel accepted after release is p(0,0); no partial window from the aborted frame is ever emitted.
- Address width of line buffers: $clog2(IMG_WIDTH).

## Structure
- Shared package/params file (`params.sv`) owns:
  - NBIT, KERNEL_SIZE
  - new IMG_WIDTH, IMG_HEIGHT macros
  - a pixel typedef of NBIT bits
- Sub-module `line_buffer`:
  - Parameters: NBIT, DEPTH.
  - Ports: i_clk, i_wr_en, i_addr, i_din, o_dout (read-before-write, registered read).
  - Instantiated KERNEL_SIZE-1 times in cascade.
- Top holds counters, window shift register, emit gating.

## Test plan
Config: NBIT=8, K=3, W=8, H=6, stimulus p(y,x)=16·y+x.
1. Continuous full frame:
   - exactly 24 valid pulses;
   - first follows accept of p(2,2) with o_data={{0,1,2},{16,17,18},{32,33,34}};
   - last = {{54,55,...}} i.e. rows 3..5, cols 5..7: {{53,54,55},{69,70,71},{85,86,87}}.
2. Random 0–3 cycle gaps between pixels: the same 24 windows in the same order, with valid only on cycles after accepts and o_data held between.
3. Line wrap: no valid after accepting x=0 or x=1 on any row. Window after p(3,2) = {{16,17,18},{32,33,34},{48,49,50}}.
4. Two back-to-back frames, second with p+100:
   - o_frame_done pulses once per frame after p(5,7);
   - second frame's first window = {{100,101,102},{116,117,118},{132,133,134}} with no stale values.
5. Reset asserted mid-frame after p(3,4):
   - o_data_valid=0 and o_data=0 within the same cycle;
   - after release, a fresh frame reproduces scenario 1 exactly.
6. Direct hookup to conv_block_sobel: the gx/gy sequence matches a software Sobel over the 4×6 valid region.
